// File: rtl/muldiv_seq_pkg.sv
// Shared constants for the multi-cycle multiply/divide sequencer: op codes,
// shared-ALU function codes, FSM state encodings and op-decoding helpers.
package muldiv_seq_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [5:0] FUNC_ADD = 6'b000000;
    localparam logic [5:0] FUNC_SUB = 6'b000001;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [4:0] ITER_LAST = 5'd31;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/cond_neg64.sv
// Conditional two's-complement negation, modulo 2^64. Narrower values are
// handled by zero-extending into the low half and taking the low half back.
module cond_neg64 (
    input  logic [63:0] in,
    input  logic        neg,
    output logic [63:0] out
);

    assign out = neg ? (~in + 64'd1) : in;

endmodule

// File: rtl/muldiv_seq.sv
// MULT/MULTU/DIV/DIVU sequencer producing HI/LO. Works on magnitudes, iterating
// 32 times through the shared external ALU, then fixes up signs before DONE.
module muldiv_seq
    import muldiv_seq_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [5:0]  alu_func,
    output logic        alu_sign,
    input  logic [31:0] alu_result,
    input  logic        alu_carry
);

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [1:0]  op_q;
    logic        neg_p;
    logic        neg_r;
    logic [31:0] opnd;      // multiplicand or divisor magnitude
    logic [31:0] acc_hi;    // product high half / remainder
    logic [31:0] acc_lo;    // multiplier being shifted out / quotient

    logic        in_signed;
    logic        is_div_q;
    logic [63:0] mag_a64;
    logic [63:0] mag_b64;
    logic [63:0] fix_lo64;
    logic [63:0] fix_rem64;
    logic [31:0] fix_hi;
    logic [31:0] fix_lo;
    logic [31:0] div_p;
    logic        take;

    assign in_signed = op_is_signed(op);
    assign is_div_q  = op_is_div(op_q);

    cond_neg64 u_mag_a (
        .in  ({32'd0, src_a}),
        .neg (in_signed & src_a[31]),
        .out (mag_a64)
    );

    cond_neg64 u_mag_b (
        .in  ({32'd0, src_b}),
        .neg (in_signed & src_b[31]),
        .out (mag_b64)
    );

    // Multiply negates the full 64-bit product; divide negates only the quotient here.
    cond_neg64 u_fix_lo (
        .in  (is_div_q ? {32'd0, acc_lo} : {acc_hi, acc_lo}),
        .neg (neg_p),
        .out (fix_lo64)
    );

    cond_neg64 u_fix_rem (
        .in  ({32'd0, acc_hi}),
        .neg (neg_r),
        .out (fix_rem64)
    );

    assign fix_hi = is_div_q ? fix_rem64[31:0] : fix_lo64[63:32];
    assign fix_lo = fix_lo64[31:0];

    logic unused_hi_halves;
    assign unused_hi_halves = &{1'b0, mag_a64[63:32], mag_b64[63:32], fix_rem64[63:32]};

    // Restoring division step: a set rem[31] means the shifted value exceeds any divisor.
    assign div_p = {acc_hi[30:0], acc_lo[31]};
    assign take  = acc_hi[31] | alu_carry;

    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);
    assign alu_sign = 1'b0;

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        alu_a    = 32'd0;
        alu_b    = 32'd0;
        alu_func = FUNC_ADD;
        if (state == S_ITER) begin
            if (is_div_q) begin
                alu_a    = div_p;
                alu_b    = opnd;
                alu_func = FUNC_SUB;
            end else begin
                alu_a = acc_hi;
                alu_b = acc_lo[0] ? opnd : 32'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= 5'd0;
            op_q        <= OP_MULT;
            neg_p       <= 1'b0;
            neg_r       <= 1'b0;
            opnd        <= 32'd0;
            acc_hi      <= 32'd0;
            acc_lo      <= 32'd0;
            div_by_zero <= 1'b0;
            hi          <= 32'd0;
            lo          <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q        <= op;
                        cnt         <= 5'd0;
                        div_by_zero <= 1'b0;
                        neg_p       <= in_signed & (src_a[31] ^ src_b[31]);
                        neg_r       <= in_signed & src_a[31];
                        acc_hi      <= 32'd0;
                        state       <= S_ITER;
                        if (op_is_div(op)) begin
                            acc_lo <= mag_a64[31:0];
                            opnd   <= mag_b64[31:0];
                            if (src_b == 32'd0) begin
                                hi          <= src_a;
                                lo          <= 32'hFFFF_FFFF;
                                div_by_zero <= 1'b1;
                                state       <= S_DONE;
                            end
                        end else begin
                            acc_lo <= mag_b64[31:0];
                            opnd   <= mag_a64[31:0];
                        end
                    end
                end
                S_ITER: begin
                    if (is_div_q) begin
                        acc_hi <= take ? alu_result : div_p;
                        acc_lo <= {acc_lo[30:0], take};
                    end else begin
                        {acc_hi, acc_lo} <= {alu_carry, alu_result, acc_lo[31:1]};
                    end
                    cnt <= cnt + 5'd1;
                    if (cnt == ITER_LAST) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    hi    <= fix_hi;
                    lo    <= fix_lo;
                    state <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq with a behavioural shared ALU on the alu_* ports.
// Stimulus pushes expected results; a monitor pops them whenever done is seen.
module tb_muldiv_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [5:0]  alu_func;
    logic        alu_sign;
    logic [31:0] alu_result;
    logic        alu_carry;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          start_cyc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int          cur_start_cyc = 0;
    logic        cur_iter      = 1'b0;
    logic        cur_is_div    = 1'b0;
    logic        prev_done     = 1'b0;
    logic [31:0] held_hi       = 32'd0;
    logic [31:0] held_lo       = 32'd0;
    int          phase;

    muldiv_seq dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .src_a       (src_a),
        .src_b       (src_b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_func    (alu_func),
        .alu_sign    (alu_sign),
        .alu_result  (alu_result),
        .alu_carry   (alu_carry)
    );

    // Behavioural shared ALU: func 0 = a+b, func 1 = a+~b+1, Ovf read as carry-out.
    logic [32:0] alu_sum;
    always_comb begin
        if (alu_func == 6'b000001) alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        else                       alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
    end
    assign alu_result = alu_sum[31:0];
    assign alu_carry  = alu_sum[32];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (reset) begin
            held_hi   = 32'd0;
            held_lo   = 32'd0;
            prev_done = 1'b0;
        end else begin
            check("alu_sign", {31'd0, alu_sign}, 32'd0);
            phase = cyc - cur_start_cyc;
            if (busy && cur_iter && phase >= 1 && phase <= 32) begin
                check("iter_alu_func", {26'd0, alu_func}, cur_is_div ? 32'd1 : 32'd0);
            end else begin
                check("idle_alu_a", alu_a, 32'd0);
                check("idle_alu_b", alu_b, 32'd0);
            end
            if (done) begin
                check("done_single_cycle", {31'd0, prev_done}, 32'd0);
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=done expected=no_done (cycle %0d)", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    check("result_hi", hi, mon_e.hi);
                    check("result_lo", lo, mon_e.lo);
                    check("div_by_zero", {31'd0, div_by_zero}, {31'd0, mon_e.dbz});
                    check("done_latency", 32'(cyc - mon_e.start_cyc), 32'(mon_e.lat));
                    check("busy_at_done", {31'd0, busy}, 32'd1);
                end
                held_hi = hi;
                held_lo = lo;
            end else if (busy) begin
                check("hi_held_while_busy", hi, held_hi);
                check("lo_held_while_busy", lo, held_lo);
            end
            prev_done = done;
        end
    end

    // Called at a falling edge; the following rising edge is cycle 0 of the operation.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e_hi, input logic [31:0] e_lo, input logic e_dbz,
                         input int lat);
        exp_t e;
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        e.hi = e_hi;
        e.lo = e_lo;
        e.dbz = e_dbz;
        e.start_cyc = cyc;
        e.lat = lat;
        sb.push_back(e);
        cur_start_cyc = cyc;
        cur_is_div    = o[1];
        cur_iter      = !(o[1] && b == 32'd0);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout pending=%0d expected=0", sb.size());
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] e_hi, input logic [31:0] e_lo, input logic e_dbz,
                          input int lat);
        issue(o, a, b, e_hi, e_lo, e_dbz, lat);
        drain();
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        src_a = 32'd0;
        src_b = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_dbz", {31'd0, div_by_zero}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_alu_func", {26'd0, alu_func}, 32'd0);
        @(negedge clk);

        // op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34);
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 34);
        run_op(2'b00, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b0, 34);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34);
        run_op(2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 34);
        run_op(2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 34);
        run_op(2'b11, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, 1'b0, 34);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0, 34);
        run_op(2'b11, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1, 1);
        run_op(2'b01, 32'd2,         32'd3,         32'd0,         32'd6,         1'b0, 34);
        run_op(2'b10, 32'hFFFF_FFF7, 32'd0,         32'hFFFF_FFF7, 32'hFFFF_FFFF, 1'b1, 1);

        // A second start at cycle 5 must be ignored.
        issue(2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 34);
        repeat (3) @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        op    = 2'b11;
        src_a = 32'd9;
        src_b = 32'd0;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (5) @(negedge clk);

        // Reset at cycle 10 aborts an operation in flight.
        start = 1'b1;
        op    = 2'b01;
        src_a = 32'd7;
        src_b = 32'd9;
        cur_start_cyc = cyc;
        cur_is_div    = 1'b0;
        cur_iter      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        @(negedge clk);
        reset    = 1'b1;
        cur_iter = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        check("abort_alu_a", alu_a, 32'd0);
        repeat (2) @(negedge clk);
        run_op(2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 34);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
